// File: rtl/fc_demux_pkg.sv
// Shared types and helpers for the FC TCDM demux family.
package fc_demux_pkg;

   // Rule fields are wide enough for any address width used by FC
   // interconnect blocks; narrower addresses are zero-extended before compare.
   localparam int unsigned RULE_AW = 64;

   // Read data returned for accesses that hit no mapped window.
   localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

   typedef struct packed {
      logic [RULE_AW-1:0] start_addr;
      logic [RULE_AW-1:0] end_addr;
   } addr_rule_t;

   // Width of an index able to address n ports (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/fc_demux_addr_decode.sv
// Combinational window decode: returns the lowest rule index >= 1 whose
// half-open window [start, end) contains the address; rule 0 is the fallback
// and is never matched here. An empty window (start >= end) cannot contain
// any address, so it never matches.
module fc_demux_addr_decode
   import fc_demux_pkg::*;
#(
   parameter int unsigned N_RULES    = 3,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  addr_rule_t                    rule_i [N_RULES],
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   output logic [idx_width(N_RULES)-1:0] sel_o,
   output logic                          match_o
);

   localparam int unsigned SEL_W = idx_width(N_RULES);

   logic [RULE_AW-1:0] addr_ext;

   assign addr_ext = RULE_AW'(addr_i);

   // Scan from the top down so the lowest matching index wins.
   always_comb begin
      sel_o   = '0;
      match_o = 1'b0;
      for (int i = int'(N_RULES) - 1; i >= 1; i--) begin
         if ((addr_ext >= rule_i[i].start_addr) && (addr_ext < rule_i[i].end_addr)) begin
            sel_o   = SEL_W'(i);
            match_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fc_tcdm_demux_nway.sv
// N-way address-decoded demux from one FC core bus port to TCDM-style
// master ports. Responses return strictly in order: a new target port is
// only accepted once every response from the previous port has come back.
// Optional macro FC_DEMUX_ERR_RESP_EN: unmapped addresses outside port 0's
// window are answered locally with an error response instead of going to
// port 0.
module fc_tcdm_demux_nway
   import fc_demux_pkg::*;
#(
   parameter int unsigned N_PORTS         = 3,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]    rule_start_i,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]    rule_end_i,
   input  logic                             req_i,
   input  logic [ADDR_WIDTH-1:0]            add_i,
   input  logic                             wen_i,
   input  logic [DATA_WIDTH-1:0]            wdata_i,
   input  logic [DATA_WIDTH/8-1:0]          be_i,
   output logic                             gnt_o,
   output logic                             r_valid_o,
   output logic [DATA_WIDTH-1:0]            r_rdata_o,
   output logic                             r_opc_o,
   output logic [N_PORTS-1:0]               mst_req_o,
   output logic [N_PORTS*ADDR_WIDTH-1:0]    mst_add_o,
   output logic [N_PORTS-1:0]               mst_wen_o,
   output logic [N_PORTS*DATA_WIDTH-1:0]    mst_wdata_o,
   output logic [N_PORTS*DATA_WIDTH/8-1:0]  mst_be_o,
   input  logic [N_PORTS-1:0]               mst_gnt_i,
   input  logic [N_PORTS-1:0]               mst_r_valid_i,
   input  logic [N_PORTS*DATA_WIDTH-1:0]    mst_r_rdata_i,
   output logic                             busy_o
);

   localparam int unsigned PORT_W = idx_width(N_PORTS);
`ifdef FC_DEMUX_ERR_RESP_EN
   localparam int unsigned CUR_W  = PORT_W + 1;
`else
   localparam int unsigned CUR_W  = PORT_W;
`endif
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   addr_rule_t          rules [N_PORTS];
   logic [PORT_W-1:0]   dec_sel;
   logic                dec_match;
   logic [CUR_W-1:0]    sel;
   logic [CUR_W-1:0]    cur_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_eff;
   logic                sel_err;
   logic                cur_err;
   logic                port_gnt;
   logic                port_rvalid;
   logic [DATA_WIDTH-1:0] port_rdata;
   logic                allow;
   logic                hs;

   // Unpack the flattened window vectors into rule structs.
   always_comb begin
      for (int i = 0; i < int'(N_PORTS); i++) begin
         rules[i].start_addr = RULE_AW'(rule_start_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
         rules[i].end_addr   = RULE_AW'(rule_end_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
      end
   end

   fc_demux_addr_decode #(
      .N_RULES    (N_PORTS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_decode (
      .rule_i  (rules),
      .addr_i  (add_i),
      .sel_o   (dec_sel),
      .match_o (dec_match)
   );

`ifdef FC_DEMUX_ERR_RESP_EN
   logic in_port0;
   logic err_rsp_q;

   assign in_port0 = (RULE_AW'(add_i) >= rules[0].start_addr) &&
                     (RULE_AW'(add_i) <  rules[0].end_addr);
   assign sel_err  = (sel == CUR_W'(N_PORTS));
   assign cur_err  = (cur_q == CUR_W'(N_PORTS));

   // Error response is produced one cycle after each locally granted request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_rsp_q <= 1'b0;
      else         err_rsp_q <= hs & sel_err;
   end
`else
   assign sel_err = 1'b0;
   assign cur_err = 1'b0;
`endif

   // Final target: decoded port, port 0 fallback, or the error pseudo-port.
   always_comb begin
      sel = CUR_W'(dec_sel);
      if (!dec_match) sel = '0;
`ifdef FC_DEMUX_ERR_RESP_EN
      if (!dec_match && !in_port0) sel = CUR_W'(N_PORTS);
`endif
   end

   // Select grant from the target port and response from the current port.
   always_comb begin
      port_gnt    = 1'b0;
      port_rvalid = 1'b0;
      port_rdata  = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
         if (sel == CUR_W'(i)) port_gnt = mst_gnt_i[i];
         if (cur_q == CUR_W'(i)) begin
            port_rvalid = mst_r_valid_i[i];
            port_rdata  = mst_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (sel_err) port_gnt = 1'b1;
`ifdef FC_DEMUX_ERR_RESP_EN
      if (cur_err) begin
         port_rvalid = err_rsp_q;
         port_rdata  = DATA_WIDTH'(ERR_RDATA);
      end
`endif
   end

   assign r_valid_o = port_rvalid & (cnt_q != '0);
   assign r_rdata_o = port_rdata;
   assign r_opc_o   = r_valid_o & cur_err;
   assign busy_o    = (cnt_q != '0);

   // The stall logic sees the count after this cycle's response, so a port
   // that drains (or a full pipeline that frees a slot) releases the waiting
   // request in the same cycle instead of one cycle later.
   assign cnt_eff = cnt_q - CNT_W'(r_valid_o);
   assign allow   = ((cnt_eff == '0) || (sel == cur_q)) &&
                    (cnt_eff < CNT_W'(MAX_OUTSTANDING));
   assign gnt_o   = req_i & allow & port_gnt;
   assign hs      = gnt_o;

   // Request goes only to the selected real port; data lines are broadcast.
   always_comb begin
      mst_req_o = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
         if (sel == CUR_W'(i)) mst_req_o[i] = req_i & allow;
      end
   end

   assign mst_add_o   = {N_PORTS{add_i}};
   assign mst_wen_o   = {N_PORTS{wen_i}};
   assign mst_wdata_o = {N_PORTS{wdata_i}};
   assign mst_be_o    = {N_PORTS{be_i}};

   // Outstanding counter and current port; grant+response cancel out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         cur_q <= '0;
      end else begin
         if (hs && !r_valid_o)      cnt_q <= cnt_q + CNT_W'(1);
         else if (!hs && r_valid_o) cnt_q <= cnt_q - CNT_W'(1);
         if (hs) cur_q <= sel;
      end
   end

endmodule
